// File: rtl/cpu_stack.sv
// rtl/cpu_stack.sv - hardware stack with registered top-of-stack and circular spill array
// Overfilling overwrites the oldest spilled entry; overflow/underflow are sticky until reset or flush.
module cpu_stack #(
   parameter int WIDTH       = 16,
   parameter int SADDR_WIDTH = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   push,
   input  logic                   pop,
   input  logic [WIDTH-1:0]       D,
   input  logic                   flush,
   output logic [WIDTH-1:0]       Q,
   output logic [WIDTH-1:0]       NOS,
   output logic [SADDR_WIDTH:0]   count,
   output logic                   empty,
   output logic                   full,
   output logic                   overflow,
   output logic                   underflow
);

   localparam int                   DEPTH     = 2 ** SADDR_WIDTH;
   localparam logic [SADDR_WIDTH:0] CAP       = (SADDR_WIDTH + 1)'(DEPTH + 1);
   localparam logic [SADDR_WIDTH:0] COUNT_ONE = (SADDR_WIDTH + 1)'(1);
   localparam logic [SADDR_WIDTH-1:0] SP_ONE  = SADDR_WIDTH'(1);

   logic [WIDTH-1:0]       mem [DEPTH];
   logic [SADDR_WIDTH-1:0] sp;
   logic [SADDR_WIDTH-1:0] sp_dec;
   logic                   wr_en;

   assign sp_dec = sp - SP_ONE;
   assign NOS    = mem[sp_dec];
   assign empty  = (count == '0);
   assign full   = (count == CAP);

   // The old TOS spills on every plain push, including from empty and when full.
   assign wr_en = reset & ~flush & push & ~pop;

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[sp] <= Q;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         Q         <= '0;
         sp        <= '0;
         count     <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else if (flush) begin
         Q         <= '0;
         sp        <= '0;
         count     <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else if (push && pop) begin
         Q <= D;
      end else if (push) begin
         Q  <= D;
         sp <= sp + SP_ONE;
         if (full) begin
            overflow <= 1'b1;
         end else begin
            count <= count + COUNT_ONE;
         end
      end else if (pop) begin
         if (empty) begin
            underflow <= 1'b1;
         end else begin
            Q     <= (count == COUNT_ONE) ? '0 : mem[sp_dec];
            sp    <= sp_dec;
            count <= count - COUNT_ONE;
         end
      end
   end

endmodule

// File: tb/tb_cpu_stack.sv
// tb/tb_cpu_stack.sv - directed and randomized checks of cpu_stack against a queue model
// Configured with SADDR_WIDTH=2 so the stack holds five entries.
module tb_cpu_stack;

   localparam int W   = 16;
   localparam int SA  = 2;
   localparam int CAP = 5;

   logic          clk = 1'b0;
   logic          reset;
   logic          push;
   logic          pop;
   logic          flush;
   logic [W-1:0]  D;
   logic [W-1:0]  Q;
   logic [W-1:0]  NOS;
   logic [SA:0]   count;
   logic          empty;
   logic          full;
   logic          overflow;
   logic          underflow;

   int passes = 0;
   int checks = 0;

   int stk[$];
   int m_q;
   bit m_ovf;
   bit m_unf;

   cpu_stack #(.WIDTH(W), .SADDR_WIDTH(SA)) dut (
      .clk(clk), .reset(reset), .push(push), .pop(pop), .D(D), .flush(flush),
      .Q(Q), .NOS(NOS), .count(count), .empty(empty), .full(full),
      .overflow(overflow), .underflow(underflow)
   );

   always #5 clk = ~clk;

   task automatic check(string tag, logic [31:0] act, logic [31:0] exp);
      checks++;
      assert (act === exp) passes++;
      else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, act, exp);
   endtask

   task automatic model_clear();
      stk.delete();
      m_q   = 0;
      m_ovf = 1'b0;
      m_unf = 1'b0;
   endtask

   // Stack semantics: stk holds every valid entry, newest last; m_q is the visible top.
   task automatic model(bit pu, bit po, bit fl, int d);
      if (fl) begin
         model_clear();
      end else if (pu && po) begin
         m_q = d;
         if (stk.size() > 0) stk[stk.size()-1] = d;
      end else if (pu) begin
         if (stk.size() == CAP) begin
            void'(stk.pop_front());
            m_ovf = 1'b1;
         end
         stk.push_back(d);
         m_q = d;
      end else if (po) begin
         if (stk.size() == 0) begin
            m_unf = 1'b1;
         end else begin
            void'(stk.pop_back());
            m_q = (stk.size() > 0) ? stk[stk.size()-1] : 0;
         end
      end
   endtask

   task automatic verify(string tag);
      check({tag, ".Q"}, 32'(Q), 32'(m_q));
      check({tag, ".count"}, 32'(count), 32'(stk.size()));
      check({tag, ".empty"}, 32'(empty), 32'(stk.size() == 0));
      check({tag, ".full"}, 32'(full), 32'(stk.size() == CAP));
      check({tag, ".overflow"}, 32'(overflow), 32'(m_ovf));
      check({tag, ".underflow"}, 32'(underflow), 32'(m_unf));
      if (stk.size() >= 2) check({tag, ".NOS"}, 32'(NOS), 32'(stk[stk.size()-2]));
   endtask

   task automatic step(string tag, bit pu, bit po, bit fl, logic [W-1:0] d);
      @(negedge clk);
      push  = pu;
      pop   = po;
      flush = fl;
      D     = d;
      @(posedge clk);
      #1;
      model(pu, po, fl, int'(d));
      verify(tag);
   endtask

   initial begin
      reset = 1'b0;
      push  = 1'b0;
      pop   = 1'b0;
      flush = 1'b0;
      D     = '0;
      model_clear();
      repeat (2) @(negedge clk);
      verify("reset");
      reset = 1'b1;

      step("push11", 1, 0, 0, 16'h11);
      step("push22", 1, 0, 0, 16'h22);
      step("push33", 1, 0, 0, 16'h33);
      check("basic.Q33", 32'(Q), 32'h33);
      check("basic.NOS22", 32'(NOS), 32'h22);
      step("pop1", 0, 1, 0, 16'h0);
      check("basic.Q22", 32'(Q), 32'h22);
      step("pop2", 0, 1, 0, 16'h0);
      step("pop3", 0, 1, 0, 16'h0);
      check("basic.Q0", 32'(Q), 32'h0);
      step("idle", 0, 0, 0, 16'hFFFF);

      for (int i = 1; i <= 6; i++) begin
         step($sformatf("wrap.push%0d", i), 1, 0, 0, W'(i));
         if (i == 5) check("wrap.full5", 32'(full), 32'h1);
      end
      check("wrap.ovf", 32'(overflow), 32'h1);
      for (int i = 0; i < 4; i++) step($sformatf("wrap.pop%0d", i), 0, 1, 0, 16'h0);
      check("wrap.Q02", 32'(Q), 32'h02);
      step("wrap.flush", 0, 0, 1, 16'h0);

      step("unf.pop", 0, 1, 0, 16'h0);
      step("unf.pushAB", 1, 0, 0, 16'hAB);
      check("unf.sticky", 32'(underflow), 32'h1);
      step("unf.flush", 0, 0, 1, 16'h0);

      step("rep.push10", 1, 0, 0, 16'h10);
      step("rep.push20", 1, 0, 0, 16'h20);
      step("rep.r99", 1, 1, 0, 16'h99);
      check("rep.NOS10", 32'(NOS), 32'h10);
      step("rep.flush", 0, 0, 1, 16'h0);
      step("rep.r55", 1, 1, 0, 16'h55);
      check("rep.empty55", 32'(Q), 32'h55);
      step("rep.popempty", 0, 1, 0, 16'h0);

      step("mid.flush", 0, 0, 1, 16'h0);
      step("mid.p1", 1, 0, 0, 16'h1);
      step("mid.p2", 1, 0, 0, 16'h2);
      step("mid.p3", 1, 0, 0, 16'h3);
      @(negedge clk);
      push = 1'b1;
      D    = 16'h77;
      #2 reset = 1'b0;
      #1;
      model_clear();
      verify("mid.async");
      @(posedge clk);
      #1;
      verify("mid.held");
      @(negedge clk);
      reset = 1'b1;
      push  = 1'b0;
      step("mid.push7", 1, 0, 0, 16'h7);

      for (int i = 0; i < 3; i++) step("fp.push", 1, 0, 0, W'(16'hA0 + i));
      step("fp.flushpush", 1, 0, 1, 16'hEE);
      check("fp.count0", 32'(count), 32'h0);

      for (int i = 0; i < 400; i++) begin
         int r;
         bit pu, po, fl;
         r  = int'($urandom_range(0, 19));
         fl = (r == 0);
         pu = (r >= 1 && r <= 10) || (r >= 17);
         po = (r >= 8);
         step($sformatf("rnd%0d", i), pu, po, fl, W'($urandom));
      end

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/cpu_stack.md
CPU_STACK -- requirements
Module: cpu_stack

Interface
REQ-001 Parameter WIDTH, default 16; data word width in bits.
REQ-002 Parameter SADDR_WIDTH, default 8; spill array holds 2**SADDR_WIDTH words, ≥1.
REQ-003 Derived CAP = 2**SADDR_WIDTH + 1 (array plus TOS register); count width SADDR_WIDTH+1.
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 reset  input  1  asynchronous, active-low; one clock; reset asynchronous, active-low.
REQ-006 push  input  1  push D onto the stack this cycle.
REQ-007 pop  input  1  discard top of stack this cycle.
REQ-008 D  input  WIDTH  data to push or replace.
REQ-009 flush  input  1  synchronous clear of stack contents and error flags.
REQ-010 Q  output  WIDTH  registered top of stack (TOS).
REQ-011 NOS  output  WIDTH  second entry (array[sp-1]), combinational read of array.
REQ-012 count  output  SADDR_WIDTH+1  number of valid entries, 0..CAP.
REQ-013 empty  output  1  count == 0.
REQ-014 full  output  1  count == CAP.
REQ-015 overflow  output  1  sticky: push occurred while full.
REQ-016 underflow  output  1  sticky: pop occurred while empty.

Function
REQ-017 State: TOS register, spill array, circular write pointer sp (SADDR_WIDTH bits, wraps modulo 2**SADDR_WIDTH), count, two sticky flags.
REQ-018 All updates on rising clk; Q, count, flags reflect an operation one cycle after it is sampled; NOS reflects new sp in the same cycle sp updates.
REQ-019 Priority: flush > (push & pop) > push > pop > idle.
REQ-020 Idle: no state changes.
REQ-021 push, not full: array[sp] <= Q, Q <= D, sp <= sp+1, count <= count+1.
REQ-022 push when count==0: Q <= D, count <= 1; array write still performed (contents don't-care), sp <= sp+1.
REQ-023 push, full: array[sp] <= Q (overwrites oldest entry), Q <= D, sp <= sp+1 (wraps), count stays CAP, overflow <= 1.
REQ-024 pop, count ≥ 2: Q <= array[sp-1], sp <= sp-1, count <= count-1.
REQ-025 pop, count == 1: Q <= 0, sp <= sp-1, count <= 0.
REQ-026 pop, empty: Q, sp, count unchanged; underflow <= 1.
REQ-027 push & pop together (replace): Q <= D; sp, count, array unchanged; no flag change, including when empty (count stays 0, Q <= D) or full.
REQ-028 flush: Q <= 0, sp <= 0, count <= 0, overflow <= 0, underflow <= 0; array contents untouched.
REQ-029 Flags clear only on reset or flush; never self-clear.
REQ-030 Single write port, single asynchronous read port on array; no read-during-write bypass needed since writes and reads never target the same address in one cycle.

Reset
REQ-031 reset low asynchronously forces Q=0, sp=0, count=0, overflow=0, underflow=0; empty=1, full=0.
REQ-032 Array contents not reset; NOS is don't-care while count < 2.
REQ-033 Reset asserted mid-operation overrides any push/pop/flush in that cycle; first operation is sampled on the first rising clk after reset deasserts.

Verification
REQ-034 SADDR_WIDTH=2 (CAP=5): push 0x11,0x22,0x33 -> Q=0x33, NOS=0x22, count=3; pop x3 -> Q=0x22, 0x11, then 0x0000, empty=1, underflow=0.
REQ-035 Push 0x01..0x06 (6 pushes into CAP=5) -> after 5th full=1; after 6th Q=0x06, count=5, overflow=1; 4 pops yield Q=0x05,0x04,0x03,0x02 (0x01 lost to wrap).
REQ-036 Empty, pop -> underflow=1, Q=0, count=0; then push 0xAB -> Q=0xAB, count=1, underflow still 1; flush -> all flags 0, count=0, Q=0.
REQ-037 Stack holds 0x10,0x20; push&pop with D=0x99 -> Q=0x99, NOS=0x10, count=2; repeat when empty with D=0x55 -> Q=0x55, count=0.
REQ-038 Stack holds 3 entries, reset pulsed low mid-cycle coincident with push -> Q=0, count=0 immediately, flags 0; push 0x7 after release -> Q=0x7, count=1.
REQ-039 flush and push asserted together with count=4 -> count=0, Q=0, push ignored.
